// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush and saturating back-pressure counter.
module pipe_stage_skid #(
    parameter int DATA_W  = 160,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
    state_t            state, state_n;
    logic [DATA_W-1:0] main_q, main_n, skid_q, skid_n;
    logic              in_fire, out_fire;

    assign out_valid = state != EMPTY;
    assign out_data  = main_q;
    assign occupancy = state;
    assign in_fire   = in_valid & in_ready & ~flush;
    assign out_fire  = out_valid & out_ready & ~flush;

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    main_n  = in_data;
                    state_n = BUSY;
                end
                BUSY: if (in_fire && out_fire) begin
                    main_n = in_data;
                end else if (in_fire && SKID_EN) begin
                    skid_n  = in_data;
                    state_n = FULL;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end
                FULL: if (out_fire) begin
                    main_n  = skid_q;
                    state_n = BUSY;
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            stall_cnt <= '0;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            if (out_valid && !out_ready && !flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic in_ready_q;
            // Registering in_ready from the next state breaks the upstream stall chain.
            always_ff @(posedge clk) begin
                if (rst) begin
                    skid_q     <= '0;
                    in_ready_q <= 1'b1;
                end else begin
                    skid_q     <= skid_n;
                    in_ready_q <= state_n != FULL;
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign skid_q   = '0;
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for the skid stage plus a non-skid, 2-bit-counter instance.
module tb_pipe_stage_skid;
    localparam int DW = 160;
    logic clk = 0, rst = 1;
    logic flush = 0, in_valid = 0, out_ready = 0;
    logic [DW-1:0] in_data = '0;
    logic a_in_ready, a_out_valid;
    logic [DW-1:0] a_out_data;
    logic [1:0] a_occ;
    logic [15:0] a_stall;
    logic b_flush = 0, b_in_valid = 0, b_out_ready = 0;
    logic [DW-1:0] b_in_data = '0;
    logic b_in_ready, b_out_valid;
    logic [DW-1:0] b_out_data;
    logic [1:0] b_occ;
    logic [1:0] b_stall;
    int checks = 0, passes = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_d;

    pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b0), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: accepted bundles are queued and must leave in order; flush/rst drop them.
    always @(negedge clk) begin
        if (rst || flush) sb.delete();
        else begin
            if (a_out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) $display("FAIL sb_empty: got out_data %0h want no output", a_out_data);
                else begin
                    exp_d = sb.pop_front();
                    if (a_out_data !== exp_d) $display("FAIL sb_data: got %0h want %0h", a_out_data, exp_d);
                    else passes++;
                end
            end
            if (in_valid && a_in_ready) sb.push_back(in_data);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1;
        tick();
        tick();
        rst = 0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) $display("FAIL reset_hs: got v=%b r=%b want v=0 r=1", a_out_valid, a_in_ready); else passes++;
        checks++; if (a_occ !== 2'd0 || a_stall !== 16'd0 || a_out_data !== '0) $display("FAIL reset_state: got occ=%0d stall=%0d d=%0h want 0 0 0", a_occ, a_stall, a_out_data); else passes++;
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_stall !== 2'd0) $display("FAIL reset_b: got v=%b r=%b stall=%0d want 0 1 0", b_out_valid, b_in_ready, b_stall); else passes++;
        tick();
    endtask

    task automatic test_streaming;
        out_ready = 1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = i <= 4;
            in_data = DW'(i);
            @(negedge clk);
            if (i > 1) begin
                checks++; if (a_out_valid !== 1'b1 || a_out_data !== DW'(i - 1)) $display("FAIL stream_data: got v=%b d=%0h want v=1 d=%0h", a_out_valid, a_out_data, i - 1); else passes++;
                checks++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1) $display("FAIL stream_occ: got occ=%0d r=%b want 1 1", a_occ, a_in_ready); else passes++;
            end
            tick();
        end
        in_valid = 0;
        @(negedge clk);
        checks++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_stall !== 16'd0) $display("FAIL stream_end: got occ=%0d v=%b stall=%0d want 0 0 0", a_occ, a_out_valid, a_stall); else passes++;
        tick();
    endtask

    task automatic test_backpressure;
        out_ready = 0;
        in_valid = 1;
        in_data = DW'('hA);
        tick();
        in_data = DW'('hB);
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1 || a_occ !== 2'd1) $display("FAIL bp_busy: got r=%b occ=%0d want 1 1", a_in_ready, a_occ); else passes++;
        tick();
        in_valid = 0;
        @(negedge clk);
        checks++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_stall !== 16'd1) $display("FAIL bp_full: got occ=%0d r=%b stall=%0d want 2 0 1", a_occ, a_in_ready, a_stall); else passes++;
        repeat (5) tick();
        @(negedge clk);
        checks++; if (a_stall !== 16'd6 || a_occ !== 2'd2 || a_out_data !== DW'('hA)) $display("FAIL bp_hold: got stall=%0d occ=%0d d=%0h want 6 2 a", a_stall, a_occ, a_out_data); else passes++;
        tick();
        out_ready = 1;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b0 || a_stall !== 16'd7) $display("FAIL bp_drain0: got r=%b stall=%0d want 0 7", a_in_ready, a_stall); else passes++;
        tick();
        @(negedge clk);
        checks++; if (a_out_data !== DW'('hB) || a_in_ready !== 1'b1 || a_occ !== 2'd1) $display("FAIL bp_drain1: got d=%0h r=%b occ=%0d want b 1 1", a_out_data, a_in_ready, a_occ); else passes++;
        tick();
        @(negedge clk);
        checks++; if (a_occ !== 2'd0 || a_stall !== 16'd7 || sb.size() != 0) $display("FAIL bp_done: got occ=%0d stall=%0d q=%0d want 0 7 0", a_occ, a_stall, sb.size()); else passes++;
        tick();
    endtask

    task automatic test_flush;
        out_ready = 0;
        in_valid = 1;
        in_data = DW'('h1A);
        tick();
        in_data = DW'('h1B);
        tick();
        in_data = DW'('hC);
        flush = 1;
        tick();
        flush = 0;
        in_valid = 0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_in_ready !== 1'b1) $display("FAIL flush_state: got v=%b occ=%0d r=%b want 0 0 1", a_out_valid, a_occ, a_in_ready); else passes++;
        checks++; if (a_out_data !== '0 || a_stall !== 16'd8) $display("FAIL flush_data: got d=%0h stall=%0d want 0 8", a_out_data, a_stall); else passes++;
        out_ready = 1;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) $display("FAIL flush_leak: got v=%b d=%0h want v=0", a_out_valid, a_out_data); else passes++;
        tick();
    endtask

    task automatic test_back_to_back;
        out_ready = 0;
        in_valid = 1;
        in_data = DW'('h5);
        tick();
        in_data = DW'('h6);
        out_ready = 1;
        tick();
        in_valid = 0;
        @(negedge clk);
        checks++; if (a_out_data !== DW'('h6) || a_occ !== 2'd1 || a_stall !== 16'd8) $display("FAIL b2b_data: got d=%0h occ=%0d stall=%0d want 6 1 8", a_out_data, a_occ, a_stall); else passes++;
        tick();
        @(negedge clk);
        checks++; if (a_occ !== 2'd0 || sb.size() != 0) $display("FAIL b2b_done: got occ=%0d q=%0d want 0 0", a_occ, sb.size()); else passes++;
        tick();
    endtask

    task automatic test_noskid;
        b_out_ready = 0;
        b_in_valid = 1;
        b_in_data = DW'('h77);
        tick();
        b_in_data = DW'('h78);
        @(negedge clk);
        checks++; if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1 || b_occ !== 2'd1) $display("FAIL ns_stall: got r=%b v=%b occ=%0d want 0 1 1", b_in_ready, b_out_valid, b_occ); else passes++;
        b_out_ready = 1;
        #1;
        checks++; if (b_in_ready !== 1'b1) $display("FAIL ns_comb: got r=%b want 1", b_in_ready); else passes++;
        b_out_ready = 0;
        repeat (6) tick();
        @(negedge clk);
        checks++; if (b_stall !== 2'd3 || b_occ !== 2'd1 || b_out_data !== DW'('h77)) $display("FAIL ns_sat: got stall=%0d occ=%0d d=%0h want 3 1 77", b_stall, b_occ, b_out_data); else passes++;
        tick();
        b_out_ready = 1;
        tick();
        b_in_valid = 0;
        @(negedge clk);
        checks++; if (b_out_data !== DW'('h78) || b_occ !== 2'd1 || b_stall !== 2'd3) $display("FAIL ns_b2b: got d=%0h occ=%0d stall=%0d want 78 1 3", b_out_data, b_occ, b_stall); else passes++;
        tick();
        @(negedge clk);
        checks++; if (b_occ !== 2'd0 || b_out_valid !== 1'b0) $display("FAIL ns_done: got occ=%0d v=%b want 0 0", b_occ, b_out_valid); else passes++;
        b_out_ready = 0;
        tick();
    endtask

    task automatic test_reset_mid;
        out_ready = 0;
        in_valid = 1;
        in_data = DW'('h21);
        tick();
        in_data = DW'('h22);
        tick();
        in_valid = 0;
        @(negedge clk);
        checks++; if (a_occ !== 2'd2 || a_stall !== 16'd9) $display("FAIL rmid_pre: got occ=%0d stall=%0d want 2 9", a_occ, a_stall); else passes++;
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_stall !== 16'd0) $display("FAIL rmid_hs: got v=%b r=%b stall=%0d want 0 1 0", a_out_valid, a_in_ready, a_stall); else passes++;
        checks++; if (a_occ !== 2'd0 || a_out_data !== '0) $display("FAIL rmid_state: got occ=%0d d=%0h want 0 0", a_occ, a_out_data); else passes++;
        tick();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_noskid();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
